// File: rtl/lbist_pkg.sv
// Shared types and default widths for the LBIST session sequencer.
// Contents: state_t session states, default parameter values, RESP_LAT upper
// bound and a small unsigned max helper used for timer sizing.
package lbist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int unsigned DEF_SETUP_DELAY = 10;
    localparam int unsigned DEF_ERR_BITS    = 8;
    localparam int unsigned DEF_PAT_BITS    = 16;
    localparam int unsigned DEF_RESP_LAT    = 2;
    localparam int unsigned RESP_LAT_MAX    = 15;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (sync, active-high), clear (sync clear), inc (count up by one),
//        count[W-1:0] (registered value, sticks at all-ones).
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/lbist_sequencer.sv
// LBIST session sequencer: holds the TPG at seed for a setup window, steps it
// one pattern per cycle until tpg_end, drains the CUT/ORA pipeline and reports
// done/pass with a saturating mismatch count.
// Ports: clk, rst (sync, active-high); start/abort session control;
//        tpg_end, ora_res from TPG/ORA; tpg_reset, tpg_inc to TPG;
//        busy, done, pass, err_count[ERR_BITS], pat_cnt[PAT_BITS] status.
// Optional: define LBIST_FAIL_LOG_EN to add first_fail_vld and
//        first_fail_idx[PAT_BITS] (response index of the first mismatch).
module lbist_sequencer
    import lbist_pkg::*;
#(
    parameter int unsigned SETUP_DELAY = DEF_SETUP_DELAY,
    parameter int unsigned ERR_BITS    = DEF_ERR_BITS,
    parameter int unsigned PAT_BITS    = DEF_PAT_BITS,
    parameter int unsigned RESP_LAT    = DEF_RESP_LAT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                tpg_end,
    input  logic                ora_res,
    output logic                tpg_reset,
    output logic                tpg_inc,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_BITS-1:0] err_count,
`ifdef LBIST_FAIL_LOG_EN
    output logic                first_fail_vld,
    output logic [PAT_BITS-1:0] first_fail_idx,
`endif
    output logic [PAT_BITS-1:0] pat_cnt
);

    localparam int unsigned SETUP_LOAD = SETUP_DELAY - 1;
    localparam int unsigned DRAIN_LOAD = (RESP_LAT > 0) ? RESP_LAT - 1 : 0;
    localparam int unsigned TMR_MAX    = max_u(SETUP_LOAD, DRAIN_LOAD);
    localparam int unsigned TMR_W      = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;

    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic             ora_vld;
    logic             sess_start;
    logic             sess_abort;
    logic             err_hit;

    // start only counts when idle/done; abort only counts while busy
    assign sess_start = start && ((state == IDLE) || (state == DONE));
    assign sess_abort = abort && ((state == SETUP) || (state == RUN) || (state == DRAIN));
    // abort freezes the counters on its own edge
    assign err_hit    = ora_vld && ora_res && !sess_abort;

    // Response-valid pipeline: tpg_inc delayed by RESP_LAT cycles
    generate
        if (RESP_LAT == 0) begin : g_no_lat
            assign ora_vld = tpg_inc;
        end else begin : g_lat
            logic [RESP_LAT-1:0] vld_sr;
            always_ff @(posedge clk) begin
                if (rst || sess_abort || sess_start) begin
                    vld_sr <= '0;
                end else begin
                    vld_sr <= (vld_sr << 1) | RESP_LAT'(tpg_inc);
                end
            end
            assign ora_vld = vld_sr[RESP_LAT-1];
        end
    endgenerate

    sat_counter #(.W(ERR_BITS)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (sess_start),
        .inc   (err_hit),
        .count (err_count)
    );

    // Session FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tmr       <= '0;
            tpg_reset <= 1'b1;
            tpg_inc   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            pat_cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= SETUP;
                        tmr       <= TMR_W'(SETUP_LOAD);
                        tpg_reset <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        pat_cnt   <= '0;
                    end
                end
                SETUP: begin
                    if (abort) begin
                        state     <= IDLE;
                        tpg_reset <= 1'b1;
                        tpg_inc   <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end else if (tmr == '0) begin
                        state     <= RUN;
                        tpg_reset <= 1'b0;
                        tpg_inc   <= 1'b1;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        tpg_reset <= 1'b1;
                        tpg_inc   <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end else begin
                        pat_cnt <= pat_cnt + PAT_BITS'(1);
                        if (tpg_end) begin
                            tpg_inc <= 1'b0;
                            if (RESP_LAT == 0) begin
                                state     <= DONE;
                                tpg_reset <= 1'b1;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                pass      <= (err_count == '0) && !err_hit;
                            end else begin
                                state <= DRAIN;
                                tmr   <= TMR_W'(DRAIN_LOAD);
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state     <= IDLE;
                        tpg_reset <= 1'b1;
                        tpg_inc   <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end else if (tmr == '0) begin
                        // pass folds in a mismatch landing on this final drain cycle
                        state     <= DONE;
                        tpg_reset <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (err_count == '0) && !err_hit;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    tpg_reset <= 1'b1;
                    tpg_inc   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef LBIST_FAIL_LOG_EN
    logic [PAT_BITS-1:0] resp_idx;

    // Capture the response index of the first valid mismatch
    always_ff @(posedge clk) begin
        if (rst || sess_start) begin
            resp_idx       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            if (ora_vld && !sess_abort) begin
                resp_idx <= resp_idx + PAT_BITS'(1);
            end
            if (err_hit && !first_fail_vld) begin
                first_fail_vld <= 1'b1;
                first_fail_idx <= resp_idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lbist_sequencer.sv
// Directed self-checking bench for lbist_sequencer: a default instance
// (ERR_BITS=8) and a narrow instance (ERR_BITS=2) share all stimulus.
// Fail-log outputs are checked when LBIST_FAIL_LOG_EN is defined.
module tb_lbist_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       tpg_end = 1'b0;
    logic       ora_res = 1'b0;

    logic       tpg_reset, tpg_inc, busy, done, pass;
    logic [7:0] err_count;
    logic [15:0] pat_cnt;
    logic       tpg_reset2, tpg_inc2, busy2, done2, pass2;
    logic [1:0] err_count2;
    logic [15:0] pat_cnt2;
`ifdef LBIST_FAIL_LOG_EN
    logic        first_fail_vld, first_fail_vld2;
    logic [15:0] first_fail_idx, first_fail_idx2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lbist_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .tpg_end(tpg_end), .ora_res(ora_res),
        .tpg_reset(tpg_reset), .tpg_inc(tpg_inc), .busy(busy),
        .done(done), .pass(pass), .err_count(err_count),
`ifdef LBIST_FAIL_LOG_EN
        .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx),
`endif
        .pat_cnt(pat_cnt)
    );

    lbist_sequencer #(.ERR_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .tpg_end(tpg_end), .ora_res(ora_res),
        .tpg_reset(tpg_reset2), .tpg_inc(tpg_inc2), .busy(busy2),
        .done(done2), .pass(pass2), .err_count(err_count2),
`ifdef LBIST_FAIL_LOG_EN
        .first_fail_vld(first_fail_vld2), .first_fail_idx(first_fail_idx2),
`endif
        .pat_cnt(pat_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One session from IDLE/DONE: mask bit j raises ora_res on response j;
    // res_setup holds ora_res high through SETUP and the pipeline-fill cycles;
    // abort_at >= 0 aborts on that RUN-relative cycle instead of finishing.
    task automatic session(input int n_run, input logic [31:0] mask,
                           input bit res_setup, input int abort_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        ora_res = res_setup;
        repeat (10) tick();
        for (int c = 0; c < n_run + 2; c++) begin
            if (c == abort_at) begin
                ora_res = 1'b0;
                abort = 1'b1;
                tick();
                abort = 1'b0;
                return;
            end
            tpg_end = (c == n_run - 1);
            ora_res = (res_setup && c < 2) || (c >= 2 && mask[c-2]);
            tick();
        end
        tpg_end = 1'b0;
        ora_res = 1'b0;
    endtask

    initial begin
        // Reset values
        tick();
        chk("rst_tpg_reset", 32'(tpg_reset), 1);
        chk("rst_tpg_inc", 32'(tpg_inc), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_pat", 32'(pat_cnt), 0);
        rst = 1'b0;

        // Setup window: tpg_reset for exactly 10 cycles, then stepping
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("setup_reset_%0d", i), 32'(tpg_reset), 1);
            chk($sformatf("setup_inc_%0d", i), 32'(tpg_inc), 0);
            tick();
        end
        chk("run_inc", 32'(tpg_inc), 1);
        chk("run_reset", 32'(tpg_reset), 0);
        chk("run_busy", 32'(busy), 1);

        // 16 patterns, clean responses, 2-cycle drain
        for (int i = 1; i <= 16; i++) begin
            tpg_end = (i == 16);
            tick();
        end
        tpg_end = 1'b0;
        chk("drain1_inc", 32'(tpg_inc), 0);
        chk("drain1_reset", 32'(tpg_reset), 0);
        chk("drain1_busy", 32'(busy), 1);
        chk("drain1_pat", 32'(pat_cnt), 16);
        tick();
        chk("drain2_done", 32'(done), 0);
        chk("drain2_busy", 32'(busy), 1);
        tick();
        chk("clean_done", 32'(done), 1);
        chk("clean_pass", 32'(pass), 1);
        chk("clean_err", 32'(err_count), 0);
        chk("clean_pat", 32'(pat_cnt), 16);
        chk("clean_busy", 32'(busy), 0);
        chk("clean_reset", 32'(tpg_reset), 1);

        // Mismatches on responses 3 and 7
        session(16, 32'h0000_0088, 1'b0, -1);
        chk("err2_done", 32'(done), 1);
        chk("err2_err", 32'(err_count), 2);
        chk("err2_pass", 32'(pass), 0);
        chk("err2_narrow_err", 32'(err_count2), 2);
`ifdef LBIST_FAIL_LOG_EN
        chk("err2_ff_vld", 32'(first_fail_vld), 1);
        chk("err2_ff_idx", 32'(first_fail_idx), 3);
`endif

        // Ten mismatches: narrow counter saturates at 3
        session(10, 32'h0000_03FF, 1'b0, -1);
        chk("sat_done", 32'(done2), 1);
        chk("sat_narrow_err", 32'(err_count2), 3);
        chk("sat_narrow_pass", 32'(pass2), 0);
        chk("sat_wide_err", 32'(err_count), 10);
        chk("sat_pat", 32'(pat_cnt), 10);
`ifdef LBIST_FAIL_LOG_EN
        chk("sat_ff_idx", 32'(first_fail_idx), 0);
`endif

        // ora_res ignored in SETUP and pipeline fill; abort on RUN cycle 5
        session(16, 32'h0, 1'b1, 5);
        chk("abort_reset", 32'(tpg_reset), 1);
        chk("abort_inc", 32'(tpg_inc), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_err", 32'(err_count), 0);
        chk("abort_pat", 32'(pat_cnt), 5);
`ifdef LBIST_FAIL_LOG_EN
        chk("abort_ff_vld", 32'(first_fail_vld), 0);
`endif

        // start+abort in IDLE: start wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 1);
        chk("sa_pat", 32'(pat_cnt), 0);
        // start while busy does not re-arm the setup window
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("restart_ign_setup", 32'(tpg_reset), 1);
        tick();
        chk("restart_ign_run", 32'(tpg_inc), 1);
        repeat (4) tick();
        chk("midrun_pat", 32'(pat_cnt), 4);

        // Reset mid-RUN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_reset", 32'(tpg_reset), 1);
        chk("mrst_inc", 32'(tpg_inc), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_pat", 32'(pat_cnt), 0);
        chk("mrst_err", 32'(err_count), 0);

        // Restart from DONE clears counters
        session(16, 32'h0000_0088, 1'b0, -1);
        chk("pre_restart_err", 32'(err_count), 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_err", 32'(err_count), 0);
        chk("restart_done", 32'(done), 0);
        chk("restart_pass", 32'(pass), 0);
        chk("restart_busy", 32'(busy), 1);
        chk("restart_reset", 32'(tpg_reset), 1);
        chk("restart_pat", 32'(pat_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
